// File: rtl/hazard_control_unit_if.sv
// Hazard controller bus: ID/EX operand info, hazard sources and pipeline register controls.
`default_nettype none

interface hazard_control_unit_if #(
   parameter int CNT_W = 32
);
   logic [4:0]       id_rs1_addr_i;
   logic [4:0]       id_rs2_addr_i;
   logic             id_rs1_rden_i;
   logic             id_rs2_rden_i;
   logic [4:0]       ex_rd_addr_i;
   logic             ex_rd_wren_i;
   logic             ex_mem_rden_i;
   logic             ex_br_taken_i;
   logic             mem_busy_i;
   logic             clr_cnt_i;
   logic             pc_en_o;
   logic             if_id_en_o;
   logic             id_ex_en_o;
   logic             ex_mem_en_o;
   logic             if_id_flush_o;
   logic             id_ex_flush_o;
   logic             mem_wb_flush_o;
   logic             mem_wait_o;
   logic             mem_timeout_o;
   logic [CNT_W-1:0] stall_cnt_o;
   logic [CNT_W-1:0] flush_cnt_o;

   modport master (
      output id_rs1_addr_i, id_rs2_addr_i, id_rs1_rden_i, id_rs2_rden_i,
             ex_rd_addr_i, ex_rd_wren_i, ex_mem_rden_i, ex_br_taken_i,
             mem_busy_i, clr_cnt_i,
      input  pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o,
             if_id_flush_o, id_ex_flush_o, mem_wb_flush_o,
             mem_wait_o, mem_timeout_o, stall_cnt_o, flush_cnt_o
   );

   modport slave (
      input  id_rs1_addr_i, id_rs2_addr_i, id_rs1_rden_i, id_rs2_rden_i,
             ex_rd_addr_i, ex_rd_wren_i, ex_mem_rden_i, ex_br_taken_i,
             mem_busy_i, clr_cnt_i,
      output pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o,
             if_id_flush_o, id_ex_flush_o, mem_wb_flush_o,
             mem_wait_o, mem_timeout_o, stall_cnt_o, flush_cnt_o
   );
endinterface

`default_nettype wire

// File: rtl/hazard_control_unit.sv
// Load-use / redirect / memory-wait hazard control with wait FSM, sticky timeout and perf counters.
`default_nettype none

module hazard_control_unit #(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 32
) (
   input  wire logic             clk_i,
   input  wire logic             rst_ni,
   hazard_control_unit_if.slave  bus
);
   localparam int              WAIT_W   = $clog2(TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);
   localparam logic [WAIT_W-1:0] WAIT_PRE = WAIT_W'(TIMEOUT - 1);

   typedef enum logic [0:0] {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_t;

   state_t            state;
   logic [WAIT_W-1:0] wait_cnt;
   logic              timeout;
   logic [CNT_W-1:0]  stall_cnt;
   logic [CNT_W-1:0]  flush_cnt;

   logic load_use;
   logic stall_evt;
   logic flush_evt;

   assign load_use = bus.ex_mem_rden_i & bus.ex_rd_wren_i & (bus.ex_rd_addr_i != 5'd0) &
                     ((bus.id_rs1_rden_i & (bus.id_rs1_addr_i == bus.ex_rd_addr_i)) |
                      (bus.id_rs2_rden_i & (bus.id_rs2_addr_i == bus.ex_rd_addr_i)));

   // A taken redirect squashes the ID instruction, so its load-use is moot.
   assign stall_evt = rst_ni & (bus.mem_busy_i | (~bus.ex_br_taken_i & load_use));
   assign flush_evt = rst_ni & ~bus.mem_busy_i & bus.ex_br_taken_i;

   always_comb begin
      bus.pc_en_o        = 1'b1;
      bus.if_id_en_o     = 1'b1;
      bus.id_ex_en_o     = 1'b1;
      bus.ex_mem_en_o    = 1'b1;
      bus.if_id_flush_o  = 1'b0;
      bus.id_ex_flush_o  = 1'b0;
      bus.mem_wb_flush_o = 1'b0;
      if (!rst_ni) begin
         bus.pc_en_o     = 1'b0;
         bus.if_id_en_o  = 1'b0;
         bus.id_ex_en_o  = 1'b0;
         bus.ex_mem_en_o = 1'b0;
      end else if (bus.mem_busy_i) begin
         bus.pc_en_o        = 1'b0;
         bus.if_id_en_o     = 1'b0;
         bus.id_ex_en_o     = 1'b0;
         bus.ex_mem_en_o    = 1'b0;
         bus.mem_wb_flush_o = 1'b1;
      end else if (bus.ex_br_taken_i) begin
         bus.if_id_flush_o = 1'b1;
         bus.id_ex_flush_o = 1'b1;
      end else if (load_use) begin
         bus.pc_en_o       = 1'b0;
         bus.if_id_en_o    = 1'b0;
         bus.id_ex_flush_o = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state     <= RUN;
         wait_cnt  <= '0;
         timeout   <= 1'b0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         state <= bus.mem_busy_i ? MEM_WAIT : RUN;

         if (!bus.mem_busy_i) begin
            wait_cnt <= '0;
         end else if (wait_cnt != WAIT_MAX) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
         end

         // Sticky: set on the edge the count reaches TIMEOUT, cleared only by reset.
         if (bus.mem_busy_i && (wait_cnt == WAIT_PRE)) begin
            timeout <= 1'b1;
         end

         if (bus.clr_cnt_i) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
         end else begin
            if (stall_evt && (stall_cnt != '1)) begin
               stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush_evt && (flush_cnt != '1)) begin
               flush_cnt <= flush_cnt + CNT_W'(1);
            end
         end
      end
   end

   assign bus.mem_wait_o    = (state == MEM_WAIT);
   assign bus.mem_timeout_o = timeout;
   assign bus.stall_cnt_o   = stall_cnt;
   assign bus.flush_cnt_o   = flush_cnt;

endmodule

`default_nettype wire

// File: doc/hazard_control_unit.md
# hazard_control_unit

Pipeline hazard controller for the 5-stage core: sits beside the forwarding unit in the ID/EX boundary and drives the enable and flush controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves three hazards that forwarding cannot:
- load-use, by inserting a one-cycle bubble;
- taken branch/jump redirect from EX, by squashing two stages;
- data-memory wait, by freezing the pipeline.

A small FSM tracks memory-wait episodes, raises a sticky timeout error, and keeps saturating stall/flush performance counters.

## Interface
Parameters:
- TIMEOUT, 255, consecutive mem_busy_i cycles after which mem_timeout_o is set (≥1)
- CNT_W, 32, width of performance counters

Ports. Clock is clk_i; reset is rst_ni, asynchronous, active-low.
- clk_i  in  1  core clock
- rst_ni  in  1  async active-low reset
- id_rs1_addr_i / id_rs2_addr_i  in  5  source registers of instruction in ID
- id_rs1_rden_i / id_rs2_rden_i  in  1  instruction in ID actually reads rs1/rs2
- ex_rd_addr_i  in  5  destination of instruction in EX
- ex_rd_wren_i  in  1  EX instruction writes rd
- ex_mem_rden_i  in  1  EX instruction is a load
- ex_br_taken_i  in  1  EX resolved a taken branch/jump (redirect)
- mem_busy_i  in  1  data memory not ready for MEM-stage access this cycle
- clr_cnt_i  in  1  synchronous clear of performance counters
- pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o  out  1  register enables
- if_id_flush_o, id_ex_flush_o, mem_wb_flush_o  out  1  insert bubble (flush wins over enable in the consuming register)
- mem_wait_o  out  1  FSM in MEM_WAIT
- mem_timeout_o  out  1  sticky timeout error
- stall_cnt_o  out  CNT_W  stall cycles (saturating)
- flush_cnt_o  out  CNT_W  redirect flush events (saturating)

## Operation
- load_use = ex_mem_rden_i & ex_rd_wren_i & (ex_rd_addr_i != 0) & ((id_rs1_rden_i & id_rs1_addr_i == ex_rd_addr_i) | (id_rs2_rden_i & id_rs2_addr_i == ex_rd_addr_i)).
- Control outputs are combinational from inputs, applied in priority order:
  1. mem_busy_i: all four enables = 0; mem_wb_flush_o = 1; other flushes = 0; stall event.
  2. ex_br_taken_i: all enables = 1; if_id_flush_o = id_ex_flush_o = 1; flush event. load_use is ignored because the ID instruction is squashed.
  3. load_use: pc_en_o = if_id_en_o = 0; id_ex_en_o = ex_mem_en_o = 1; id_ex_flush_o = 1; stall event.
  4. Otherwise: all enables = 1, all flushes = 0.
- A branch held in EX during mem_busy_i stays frozen there and is acted on in the first non-busy cycle; no latching is required.
- FSM states:
  - RUN → MEM_WAIT on an edge with mem_busy_i = 1.
  - MEM_WAIT → RUN on an edge with mem_busy_i = 0.
  - mem_wait_o = (state == MEM_WAIT).
- wait_cnt, width $clog2(TIMEOUT+1):
  - Counts consecutive busy cycles and saturates at TIMEOUT.
  - Clears to 0 on any edge with mem_busy_i = 0.
  - mem_timeout_o sets on the edge where wait_cnt reaches TIMEOUT and stays set until reset.
- Counters:
  - stall_cnt_o increments by 1 per stall event; flush_cnt_o increments by 1 per flush event.
  - Both saturate at all-ones.
  - clr_cnt_i = 1 zeroes both on the next edge and wins over a simultaneous increment.

## Timing
- Control outputs have zero latency: same-cycle response to inputs, with no registered path.
- While rst_ni = 0:
  - all enables = 0, all flushes = 0;
  - state = RUN, wait_cnt = 0, mem_wait_o = 0, mem_timeout_o = 0, counters = 0.
- Reset asserted mid-operation takes effect immediately (asynchronous) and discards any in-progress MEM_WAIT and timeout progress.
- mem_wait_o rises one cycle after the first busy cycle and falls one cycle after the first non-busy cycle.
- With TIMEOUT = N and mem_busy_i high for N consecutive cycles, mem_timeout_o is high from the cycle after the Nth busy cycle. With N−1 busy cycles, it never sets.
- A load-use stall lasts exactly one cycle: after the bubble, the load is in MEM and load_use deasserts naturally.

## Test plan
- Load x5 in EX (ex_mem_rden_i = 1, ex_rd_addr_i = 5); ID reads rs2 = 5 with id_rs2_rden_i = 1 → pc_en_o = if_id_en_o = 0, id_ex_flush_o = 1 for 1 cycle; stall_cnt_o 0→1. Repeat with rd = 0, or with id_rs2_rden_i = 0 → no stall.
- ex_br_taken_i pulse for 1 cycle with load_use also true → if_id_flush_o = id_ex_flush_o = 1, enables all 1; flush_cnt_o = 1, stall_cnt_o unchanged.
- mem_busy_i high for 3 cycles while ex_br_taken_i = 1:
  - during busy: enables 0, mem_wb_flush_o = 1, mem_wait_o high cycles 2–4;
  - first cycle after busy: redirect flush;
  - final counts: stall_cnt_o = 3, flush_cnt_o = 1.
- TIMEOUT = 4:
  - busy for 3 cycles, low for 1, busy for 3 → mem_timeout_o stays 0;
  - then busy for 4 consecutive cycles → mem_timeout_o = 1 on the next cycle and remains 1 after busy drops, until rst_ni pulses low.
- CNT_W = 3: 9 stall events → stall_cnt_o saturates at 7. Then clr_cnt_i asserted on the same cycle as a stall → counter = 0 next cycle.
- Assert rst_ni low asynchronously mid-MEM_WAIT → outputs immediately return to reset values; after release with mem_busy_i = 0 → normal RUN operation.
